pipe_stage_reg: RTL and testbench

Parametrised successor to the fixed IF/ID register. It is a one-stage pipeline register carrying a PC/instruction pair with a valid/ready handshake, an optional skid entry, and flush with a selectable delay-slot-keep mode. It also has a saturating stall-cycle counter. It sits between any two pipeline stages (IF/ID first, then ID/EX and later stages), replacing the bubble-style stall input with backpressure.

---
 rtl/pipe_stage_reg_pkg.sv | 15 +
 rtl/pipe_skid_entry.sv | 31 +++
 rtl/pipe_stage_reg.sv | 108 ++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared constants and types for the pipeline stage register
package pipe_stage_reg_pkg;

  localparam logic        RST_ASSERT = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;

  // Source selected for the main entry on a given cycle
  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_IN   = 2'd1,
    SRC_SKID = 2'd2
  } load_src_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - one valid-tagged data slot with load, clear-to-empty and async reset
module pipe_skid_entry
  import pipe_stage_reg_pkg::*;
#(
  parameter int             W     = 64,
  parameter logic [W-1:0]   EMPTY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] data
);

  // An empty slot always carries the EMPTY pattern so its data reads as a NOP
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERT) begin
      valid <= 1'b0;
      data  <= EMPTY;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= EMPTY;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - PC/instruction pipeline register with handshake, skid entry, flush and stall counter
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int INST_W    = 32,
  parameter bit SKID      = 1'b1,
  parameter bit KEEP_SLOT = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int             W       = ADDR_W + INST_W;
  localparam logic [W-1:0]   EMPTY   = {ADDR_W'(ZERO_WORD), INST_W'(NOP_INST)};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic         xfer_in, xfer_out;
  logic         skid_valid, skid_valid_next;
  logic [W-1:0] main_data, skid_data, in_data, main_d;
  logic         main_load, main_clear, skid_load, skid_clear;
  load_src_e    main_src;

  assign in_data  = {in_pc, in_inst};
  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  // Flush first; a full skid drains before anything new can reach main
  always_comb begin
    main_src   = SRC_HOLD;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      skid_clear = 1'b1;
      if (KEEP_SLOT && xfer_in) main_src = SRC_IN;
      else                      main_clear = 1'b1;
    end else if (SKID && skid_valid && xfer_out) begin
      main_src   = SRC_SKID;
      skid_clear = 1'b1;
    end else if (xfer_in && (!out_valid || xfer_out)) begin
      main_src = SRC_IN;
    end else if (xfer_in) begin
      skid_load = SKID;
    end else if (xfer_out) begin
      main_clear = 1'b1;
    end
  end

  assign main_load       = (main_src != SRC_HOLD);
  assign main_d          = (main_src == SRC_SKID) ? skid_data : in_data;
  assign skid_valid_next = skid_load | (skid_valid & ~skid_clear);

  pipe_skid_entry #(.W(W), .EMPTY(EMPTY)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (out_valid),
    .data  (main_data)
  );

  pipe_skid_entry #(.W(W), .EMPTY(EMPTY)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_data),
    .valid (skid_valid),
    .data  (skid_data)
  );

  assign out_pc   = main_data[W-1:INST_W];
  assign out_inst = main_data[INST_W-1:0];

  generate
    if (SKID) begin : g_skid_ready
      logic rdy_q;
      always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ASSERT) rdy_q <= 1'b0;
        else                   rdy_q <= ~skid_valid_next;
      end
      assign in_ready = rdy_q;
    end else begin : g_comb_ready
      assign in_ready = out_ready | ~out_valid | (flush & KEEP_SLOT);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERT)                                  stall_cnt <= CNT_W'(ZERO_WORD);
    else if (cnt_clr)                                       stall_cnt <= CNT_W'(ZERO_WORD);
    else if (out_valid && !out_ready && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg in three configurations
module tb_pipe_stage_reg;

  logic        clk, rst, iv, ordy, fl, clr;
  logic [31:0] ipc, iinst;
  logic        ir[3];
  logic        ov[3];
  logic [31:0] opc[3], oinst[3];
  logic [3:0]  sc0;
  logic [15:0] sc1, sc2;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut 0: skid, keep slot, 4-bit counter; dut 1: skid, drop slot; dut 2: no skid, keep slot
  pipe_stage_reg #(.SKID(1'b1), .KEEP_SLOT(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir[0]), .in_pc(ipc), .in_inst(iinst),
    .flush(fl), .out_valid(ov[0]), .out_ready(ordy), .out_pc(opc[0]), .out_inst(oinst[0]),
    .cnt_clr(clr), .stall_cnt(sc0));
  pipe_stage_reg #(.SKID(1'b1), .KEEP_SLOT(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir[1]), .in_pc(ipc), .in_inst(iinst),
    .flush(fl), .out_valid(ov[1]), .out_ready(ordy), .out_pc(opc[1]), .out_inst(oinst[1]),
    .cnt_clr(clr), .stall_cnt(sc1));
  pipe_stage_reg #(.SKID(1'b0), .KEEP_SLOT(1'b1), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir[2]), .in_pc(ipc), .in_inst(iinst),
    .flush(fl), .out_valid(ov[2]), .out_ready(ordy), .out_pc(opc[2]), .out_inst(oinst[2]),
    .cnt_clr(clr), .stall_cnt(sc2));

  // Reference model: each stage is a FIFO of accepted beats with capacity 2 (skid) or 1
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } beat_t;

  bit    sk[3];
  bit    kp[3];
  int    cmax[3];
  beat_t mq[3][2];
  int    msz[3];
  bit    mst[3];
  int    mcnt[3];

  typedef struct {
    bit          r, v;
    logic [31:0] pc;
    bit          ordy, fl, clr;
    bit          e_ov;
    logic [31:0] e_pc;
    bit          e_ir;
    int          e_cnt;
    bit          e_ovb;
  } tv_t;

  tv_t tv[14];

  function automatic int get_sc(input int d);
    case (d)
      0:       return int'(sc0);
      1:       return int'(sc1);
      default: return int'(sc2);
    endcase
  endfunction

  function automatic bit m_ready(input int d);
    if (sk[d]) return mst[d] && (msz[d] < 2);
    return ordy || (msz[d] == 0) || (fl && kp[d]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      msz[d] = 0; mst[d] = 1'b0; mcnt[d] = 0;
    end
  endtask

  task automatic model_check();
    if (!rst) model_reset();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d out_valid", d), 32'(ov[d]), 32'(msz[d] > 0));
      chk($sformatf("dut%0d out_pc", d), opc[d], (msz[d] > 0) ? mq[d][0].pc : 32'h0);
      chk($sformatf("dut%0d out_inst", d), oinst[d], (msz[d] > 0) ? mq[d][0].inst : 32'h0);
      chk($sformatf("dut%0d in_ready", d), 32'(ir[d]), 32'(m_ready(d)));
      chk($sformatf("dut%0d stall_cnt", d), get_sc(d), mcnt[d]);
    end
  endtask

  task automatic advance();
    bit    xin, xout, stall;
    beat_t nb;
    nb = '{pc: ipc, inst: iinst};
    for (int d = 0; d < 3; d++) begin
      xin   = iv && m_ready(d);
      xout  = (msz[d] > 0) && ordy;
      stall = (msz[d] > 0) && !ordy;
      if (rst) begin
        mst[d] = 1'b1;
        if (fl) begin
          msz[d] = 0;
          if (kp[d] && xin) begin mq[d][0] = nb; msz[d] = 1; end
        end else begin
          if (xout) begin mq[d][0] = mq[d][1]; msz[d]--; end
          if (xin && msz[d] < 2) begin mq[d][msz[d]] = nb; msz[d]++; end
        end
        if (clr) mcnt[d] = 0;
        else if (stall && mcnt[d] < cmax[d]) mcnt[d]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit v, input logic [31:0] pc, input bit o, input bit f, input bit c);
    rst = r; iv = v; ipc = pc; iinst = pc ^ 32'h2402_0401; ordy = o; fl = f; clr = c;
  endtask

  initial begin
    sk   = '{1'b1, 1'b1, 1'b0};
    kp   = '{1'b1, 1'b0, 1'b1};
    cmax = '{15, 65535, 65535};
    model_reset();

    //        r  v  pc          o  f  c   ov pc          ir cnt ovb
    tv[0]  = '{1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 0, 1'b1};
    tv[4]  = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 0, 1'b1};
    tv[6]  = '{1'b1, 1'b1, 32'h10C, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 2, 1'b1};
    tv[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 3, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 4, 1'b1};
    tv[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h108, 1'b1, 4, 1'b1};
    tv[11] = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 4, 1'b0};
    tv[12] = '{1'b1, 1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 4, 1'b1};
    tv[13] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 5, 1'b0};

    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(tv[i].r, tv[i].v, tv[i].pc, tv[i].ordy, tv[i].fl, tv[i].clr);
      #1;
      model_check();
      chk($sformatf("row%0d a.out_valid", i), 32'(ov[0]), 32'(tv[i].e_ov));
      chk($sformatf("row%0d a.out_pc", i), opc[0], tv[i].e_pc);
      chk($sformatf("row%0d a.in_ready", i), 32'(ir[0]), 32'(tv[i].e_ir));
      chk($sformatf("row%0d a.stall_cnt", i), 32'(sc0), tv[i].e_cnt);
      chk($sformatf("row%0d b.out_valid", i), 32'(ov[1]), 32'(tv[i].e_ovb));
      advance();
    end

    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1; model_check(); advance();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1; model_check();
    chk("saturate a.stall_cnt", 32'(sc0), 32'd15);
    advance();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1; model_check();
    chk("clear a.stall_cnt", 32'(sc0), 32'd0);
    advance();

    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    #1; model_check(); advance();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("noskid held in_ready", 32'(ir[2]), 32'd0);
    fl = 1'b1;
    #1;
    chk("noskid flush in_ready", 32'(ir[2]), 32'd1);
    model_check(); advance();

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      #1; model_check(); advance();
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, i < 8, 32'(4 * i), 1'b1, 1'b0, 1'b0);
      #1; model_check();
      if (i > 0) begin
        chk($sformatf("stream%0d a.out_valid", i), 32'(ov[0]), 32'd1);
        chk($sformatf("stream%0d a.out_pc", i), opc[0], 32'(4 * (i - 1)));
      end
      advance();
    end
    chk("stream a.stall_cnt", 32'(sc0), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) != 0);
      iv    = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 2) != 0);
      fl    = ($urandom_range(0, 15) == 0);
      clr   = ($urandom_range(0, 31) == 0);
      ipc   = $urandom;
      iinst = $urandom;
      #1; model_check(); advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
